// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared width default, command encoding and strobe decode helpers
package mult_pkg;

  localparam int MULT_W = 8;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLRLD,
    CMD_CLRA,
    CMD_ADD,
    CMD_SUB,
    CMD_SHIFT
  } cmd_e;

  // Strobe priority: Clr_Ld > Clear_A > Sub > Add > Shift
  function automatic cmd_e encode_cmd(input logic clr_ld, input logic clear_a,
                                      input logic add, input logic sub,
                                      input logic shift);
    cmd_e c;
    c = CMD_NONE;
    if (clr_ld)       c = CMD_CLRLD;
    else if (clear_a) c = CMD_CLRA;
    else if (sub)     c = CMD_SUB;
    else if (add)     c = CMD_ADD;
    else if (shift)   c = CMD_SHIFT;
    return c;
  endfunction

  function automatic logic multi_strobe(input logic [4:0] strobes);
    return $countones(strobes) > 1;
  endfunction

endpackage

// File: rtl/mult_addsub9.sv
// rtl/mult_addsub9.sv - (W+1)-bit sign-extended add/subtract of a and s
module mult_addsub9
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] s,
  input  logic         sub,
  output logic [W:0]   sum
);

  logic [W:0] a_ext;
  logic [W:0] s_ext;

  assign a_ext = {a[W-1], a};
  assign s_ext = {s[W-1], s};
  assign sum   = sub ? (a_ext - s_ext) : (a_ext + s_ext);

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - X:A:B register chain of the shift-add multiplier; MULT_STEP_CNT_EN adds Step_Cnt/Done
module mult_datapath
  import mult_pkg::*;
#(
  parameter int W = MULT_W
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Clr_Ld,
  input  logic         Clear_A,
  input  logic         Add,
  input  logic         Sub,
  input  logic         Shift,
  input  logic [W-1:0] S,
  output logic         M,
  output logic         X,
  output logic [W-1:0] Aval,
  output logic [W-1:0] Bval,
  output logic         Cmd_Err
`ifdef MULT_STEP_CNT_EN
  ,
  output logic [$clog2(W+1)-1:0] Step_Cnt,
  output logic                   Done
`endif
);

  cmd_e       cmd;
  logic       illegal;
  logic       shift_blocked;
  logic [W:0] sum;

  assign cmd     = encode_cmd(Clr_Ld, Clear_A, Add, Sub, Shift);
  assign illegal = multi_strobe({Clr_Ld, Clear_A, Sub, Add, Shift});
  assign M       = Bval[0];

  mult_addsub9 #(.W(W)) u_addsub (
    .a   (Aval),
    .s   (S),
    .sub (cmd == CMD_SUB),
    .sum (sum)
  );

`ifdef MULT_STEP_CNT_EN
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] STEP_MAX = CW'(W);

  assign Done          = (Step_Cnt == STEP_MAX);
  // Once all W steps are done, further shifts would corrupt the product
  assign shift_blocked = (cmd == CMD_SHIFT) && Done;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Step_Cnt <= '0;
    end else if (cmd == CMD_CLRLD || cmd == CMD_CLRA) begin
      Step_Cnt <= '0;
    end else if (cmd == CMD_SHIFT && !shift_blocked) begin
      Step_Cnt <= Step_Cnt + CW'(1);
    end
  end
`else
  assign shift_blocked = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      X       <= 1'b0;
      Aval    <= '0;
      Bval    <= '0;
      Cmd_Err <= 1'b0;
    end else begin
      Cmd_Err <= illegal | shift_blocked;
      case (cmd)
        CMD_CLRLD: begin
          X    <= 1'b0;
          Aval <= '0;
          Bval <= S;
        end
        CMD_CLRA: begin
          X    <= 1'b0;
          Aval <= '0;
        end
        CMD_ADD, CMD_SUB: begin
          X    <= sum[W];
          Aval <= sum[W-1:0];
        end
        CMD_SHIFT: begin
          if (!shift_blocked) begin
            Aval <= {X, Aval[W-1:1]};
            Bval <= {Aval[0], Bval[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - randomized and directed checks of mult_datapath against an arithmetic model
module tb_mult_datapath;

  localparam int W = 8;
  localparam logic [4:0] ST_NONE  = 5'b00000;
  localparam logic [4:0] ST_CLRLD = 5'b10000;
  localparam logic [4:0] ST_CLRA  = 5'b01000;
  localparam logic [4:0] ST_SUB   = 5'b00100;
  localparam logic [4:0] ST_ADD   = 5'b00010;
  localparam logic [4:0] ST_SHIFT = 5'b00001;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Clr_Ld = 1'b0, Clear_A = 1'b0, Add = 1'b0, Sub = 1'b0, Shift = 1'b0;
  logic [W-1:0] S = '0;
  logic         M, X, Cmd_Err;
  logic [W-1:0] Aval, Bval;
`ifdef MULT_STEP_CNT_EN
  logic [$clog2(W+1)-1:0] Step_Cnt;
  logic                   Done;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model state: xa is X:A as a signed 9-bit value, b is B as 0..255
  int xa, b, cnt;
  bit exp_err;

  mult_datapath #(.W(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr_Ld  (Clr_Ld),
    .Clear_A (Clear_A),
    .Add     (Add),
    .Sub     (Sub),
    .Shift   (Shift),
    .S       (S),
    .M       (M),
    .X       (X),
    .Aval    (Aval),
    .Bval    (Bval),
    .Cmd_Err (Cmd_Err)
`ifdef MULT_STEP_CNT_EN
    ,
    .Step_Cnt(Step_Cnt),
    .Done    (Done)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sx8(input int v);
    int t;
    t = v & 255;
    return (t >= 128) ? t - 256 : t;
  endfunction

  task automatic model_reset();
    xa = 0; b = 0; cnt = 0; exp_err = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] st, input logic [7:0] sv);
    int r, full;
    exp_err = ($countones(st) >= 2);
    if (st[4]) begin
      xa = 0; b = int'(sv); cnt = 0;
    end else if (st[3]) begin
      xa = 0; cnt = 0;
    end else if (st[2] || st[1]) begin
      r = st[2] ? sx8(xa) - sx8(int'(sv)) : sx8(xa) + sx8(int'(sv));
      r = r & 511;
      xa = (r >= 256) ? r - 512 : r;
    end else if (st[0]) begin
`ifdef MULT_STEP_CNT_EN
      if (cnt == W) begin
        exp_err = 1'b1;
      end else begin
        full = xa * 256 + b;
        full = full >>> 1;
        xa = full >>> 8;
        b = full & 255;
        cnt++;
      end
`else
      full = xa * 256 + b;
      full = full >>> 1;
      xa = full >>> 8;
      b = full & 255;
`endif
    end
  endtask

  task automatic check_model();
    chk("X", 32'(X), 32'(xa < 0));
    chk("A", 32'(Aval), 32'(xa & 255));
    chk("B", 32'(Bval), 32'(b));
    chk("M", 32'(M), 32'(b & 1));
    chk("Cmd_Err", 32'(Cmd_Err), 32'(exp_err));
`ifdef MULT_STEP_CNT_EN
    chk("Step_Cnt", 32'(Step_Cnt), 32'(cnt));
    chk("Done", 32'(Done), 32'(cnt == W));
`endif
  endtask

  task automatic cyc(input logic [4:0] st, input logic [7:0] sv);
    {Clr_Ld, Clear_A, Sub, Add, Shift} = st;
    S = sv;
    @(posedge Clk);
    model_step(st, sv);
    #1;
    check_model();
  endtask

  // Controller-style signed multiply: add (sub on last step) when M=1, then shift
  task automatic mul(input logic [7:0] bop, input logic [7:0] sop);
    int p;
    cyc(ST_CLRLD, bop);
    for (int i = 0; i < W; i++) begin
      if ((b & 1) == 1) cyc((i == W - 1) ? ST_SUB : ST_ADD, sop);
      cyc(ST_SHIFT, 8'($urandom));
    end
    p = sx8(int'(bop)) * sx8(int'(sop));
    chk("product", 32'({Aval, Bval}), 32'(p & 16'hFFFF));
  endtask

  initial begin
    logic [4:0] st;
    int r;
    model_reset();
    repeat (2) @(negedge Clk);
    check_model();
    Reset_n = 1'b1;

    // Load
    cyc(ST_CLRLD, 8'h07);
    chk("load_B", 32'(Bval), 32'h07);
    chk("load_M", 32'(M), 32'h1);

    // 7 x 59
    mul(8'h07, 8'h3B);
    chk("pos_AB", 32'({Aval, Bval}), 32'h019D);
    chk("pos_X", 32'(X), 32'h0);

    // -3 x 5
    mul(8'hFD, 8'h05);
    chk("neg_AB", 32'({Aval, Bval}), 32'hFFF1);
    chk("neg_X", 32'(X), 32'h1);

    // Most-negative operand boundaries
    mul(8'h80, 8'h80);
    mul(8'h80, 8'h7F);
    mul(8'hFF, 8'h80);

    // Illegal Add+Shift: Add wins, error pulses once
    cyc(ST_CLRLD, 8'h00);
    cyc(ST_ADD, 8'h10);
    cyc(ST_ADD | ST_SHIFT, 8'h01);
    chk("illegal_A", 32'(Aval), 32'h11);
    chk("illegal_B", 32'(Bval), 32'h00);
    chk("illegal_err", 32'(Cmd_Err), 32'h1);
    cyc(ST_NONE, 8'h33);
    chk("illegal_err_clear", 32'(Cmd_Err), 32'h0);

    // Clear_A keeps B; S changes while idle have no effect
    cyc(ST_CLRLD, 8'hA5);
    cyc(ST_SUB, 8'h22);
    cyc(ST_NONE, 8'hFF);
    cyc(ST_CLRA, 8'h11);
    chk("clra_B", 32'(Bval), 32'hA5);

`ifdef MULT_STEP_CNT_EN
    cyc(ST_CLRLD, 8'h5A);
    for (int i = 0; i < 9; i++) cyc(ST_SHIFT, 8'h00);
    chk("sat_cnt", 32'(Step_Cnt), 32'd8);
    chk("sat_done", 32'(Done), 32'h1);
    chk("sat_err", 32'(Cmd_Err), 32'h1);
`endif

    // Randomized command stream
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) st = 5'b00001 << $urandom_range(0, 4);
      else if (r == 7) st = ST_NONE;
      else st = 5'($urandom_range(0, 31));
      cyc(st, 8'($urandom));
    end

    // Random signed multiplies
    for (int i = 0; i < 10; i++) mul(8'($urandom), 8'($urandom));

    // Asynchronous reset mid-Add
    cyc(ST_CLRLD, 8'h00);
    cyc(ST_ADD, 8'h55);
    {Clr_Ld, Clear_A, Sub, Add, Shift} = ST_ADD;
    S = 8'h01;
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_X", 32'(X), 32'h0);
    chk("rst_A", 32'(Aval), 32'h00);
    chk("rst_B", 32'(Bval), 32'h00);
    chk("rst_err", 32'(Cmd_Err), 32'h0);
    chk("rst_M", 32'(M), 32'h0);
    {Clr_Ld, Clear_A, Sub, Add, Shift} = ST_NONE;
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(ST_NONE, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Responder side of the multiplier controller command interface.
- Executes the controller's per-cycle command strobes (Clr_Ld, Clear_A, Add, Sub, Shift) on the X:A:B register chain.
- Returns M (multiplier LSB) to the controller.
- Sits between the switch input S and the hex display outputs in the 8x8 signed shift-add multiplier.

Parameters:
- W, 8, operand width of A, B and S. The product is 2W bits, X:A:B holds 2W+1 bits.

Ports:
- Clk  input  1  system clock, all state updates on the rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Clr_Ld  input  1  strobe: clear X and A, load B from S
- Clear_A  input  1  strobe: clear X and A, keep B
- Add  input  1  strobe: X:A <= sext(A) + sext(S)
- Sub  input  1  strobe: X:A <= sext(A) - sext(S)
- Shift  input  1  strobe: arithmetic right shift of X:A:B by one
- S  input  W  switch operand (multiplicand / load value)
- M  output  1  current B[0], combinational from the register
- X  output  1  sign-extension bit
- Aval  output  W  register A (product high half)
- Bval  output  W  register B (product low half)
- Cmd_Err  output  1  registered, high for one cycle after an illegal strobe combination

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - X=0, A=0, B=0, Cmd_Err=0; M is therefore 0.
  - Reset mid-operation discards all state immediately.
- One command executes per rising edge; all results are visible the cycle after the strobe (latency 1).
- Idle cycles (no strobe) hold all registers.
- Arithmetic is (W+1)-bit two's complement:
  - sum = {A[W-1],A} + {S[W-1],S}, or minus for Sub.
  - X <= sum[W], A <= sum[W-1:0]; B is unchanged.
  - No saturation. The carry out of bit W is discarded.
- Shift:
  - X <= X; A <= {X, A[W-1:1]}; B <= {A[0], B[W-1:1]}.
  - X therefore replicates the sign.
- Clr_Ld: X <= 0, A <= 0, B <= S.
- Clear_A: X <= 0, A <= 0, B held.
- Priority when several strobes are high in the same cycle: Clr_Ld > Clear_A > Sub > Add > Shift. Only the winner executes.
- Any cycle with two or more strobes high is illegal and sets Cmd_Err=1 on the next cycle, for one cycle only. The cycle after that, Cmd_Err clears unless the violation repeats.
- S is sampled only on an Add, Sub or Clr_Ld edge. S changes between strobes have no effect.
- Add or Sub with S = -2^(W-1) is legal. The W+1-bit sum holds the full range.

Optional Feature:
- Macro: MULT_STEP_CNT_EN.
- Defined:
  - Adds output Step_Cnt [$clog2(W+1)-1:0] and output Done (1 bit).
  - Step_Cnt resets to 0, clears on Clr_Ld or Clear_A, and increments on each executed Shift, saturating at W.
  - Done = (Step_Cnt == W), combinational.
  - A Shift while Done=1 is not executed (registers hold) and sets Cmd_Err on the next cycle.
- Undefined:
  - Neither port exists and Shift is never suppressed.
  - All other behaviour is identical.

Decomposition:
- Shared package mult_pkg holds:
  - Parameter default MULT_W=8.
  - typedef enum cmd_e {CMD_NONE, CMD_CLRLD, CMD_CLRA, CMD_ADD, CMD_SUB, CMD_SHIFT}, shared with the controller.
  - A function that encodes the strobe vector to cmd_e by priority.
- One natural sub-module, mult_addsub9: a combinational (W+1)-bit add/subtract unit with inputs a, s, sub and output sum[W:0].
- The register chain and error logic stay in mult_datapath.

Test Plan:
- Reset: drive Reset_n low mid-Add with A=0x55 → X=0, A=0x00, B=0x00, Cmd_Err=0 immediately, before the next edge.
- Load: S=0x07, pulse Clr_Ld → B=0x07, A=0x00, X=0, M=1.
- Full multiply 7×59 with the controller sequence (Add on M=1, Shift, Sub on the 8th step if M=1):
  - Stimulus: B=0x07, S=0x3B.
  - Result: A:B=0x019D, X=0.
- Negative product −3×5:
  - Stimulus: B=0xFD, S=0x05; the 8th step uses Sub.
  - Result: A:B=0xFFF1, X=1.
- Illegal combo: Add and Shift high together with A=0x10, S=0x01 → A=0x11, no shift, Cmd_Err=1 for exactly one cycle.
- With MULT_STEP_CNT_EN: after Clr_Ld, apply 9 Shift pulses → Step_Cnt stops at 8, Done=1, the 9th Shift leaves registers unchanged and sets Cmd_Err=1.
